game_timer_bcd: RTL and testbench
=================================

Name: game_timer_bcd

Overview:
Parametrised game-time counter that drives DIGITS BCD digits (one per 7-segment display) from a divided clock tick. It supports a loadable start value, up or down counting, start/pause/resume control, run-time speed scaling and a terminal-count flag. It sits between the game FSM (which loads, starts, pauses and watches Expired) and the per-digit hex decoders.

Parameters:
CLOCK_FREQUENCY, 50000000, ClockIn cycles per tick at Speed=0 (1 s at 50 MHz); must be >= 8.
DIGITS, 2, number of BCD digits; 1..8.

Ports:
ClockIn  in  1  system clock
Reset  in  1  synchronous, active-high reset
Load  in  1  load LoadValue and enter IDLE
LoadValue  in  4*DIGITS  BCD start value; digit i is bits [4i+3:4i], digit 0 = ones
Start  in  1  start from IDLE or resume from PAUSED
Pause  in  1  pause while RUN
Mode  in  1  0 = count up, 1 = count down; sampled only on Start from IDLE
Speed  in  2  tick period = CLOCK_FREQUENCY >> Speed
Value  out  4*DIGITS  current BCD value
Running  out  1  high in RUN
Tick  out  1  one-cycle pulse on each value update
Expired  out  1  one-cycle pulse on reaching terminal count
Done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; Value=0, Tick=0, Expired=0, Running=0, Done=0; divider=(CLOCK_FREQUENCY>>Speed)-1; latched mode=down.
- Control priority each cycle: Reset > Load > Pause > Start.
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE: Start -> RUN; latch Mode; reload divider.
  - RUN: Pause -> PAUSED. Terminal update -> DONE.
  - PAUSED: divider and Value are frozen. Start -> RUN and resume from the held divider count, with no reload.
  - DONE: Value held. Start is ignored. Only Load or Reset leaves DONE.
- Load in any state:
  - Next state IDLE; Value<=LoadValue; divider reloaded; Done=0.
  - Any LoadValue digit > 9 is clamped to 9.
- Divider:
  - Counts down once per cycle only in RUN.
  - In RUN with divider==0, on the next edge: Value is updated, Tick<=1, and the divider is reloaded with (CLOCK_FREQUENCY>>Speed)-1.
  - Speed is sampled only at reload.
  - First Tick is asserted exactly N=CLOCK_FREQUENCY>>Speed cycles after the edge that accepted Start. Ticks then repeat every N cycles while in RUN.
- Count arithmetic (all digit carries and borrows resolve in the same cycle):
  - Down: BCD decrement with borrow ripple (x0 -> (x-1)9).
  - Up: BCD increment with carry ripple (x9 -> (x+1)0).
- Terminal count:
  - Down: the update producing all-zero sets Expired<=1 in the same edge as Value becomes 0; state -> DONE.
  - Up: the update producing all-nines (99..9) sets Expired<=1; state -> DONE.
  - No wrap-around in either mode; the terminal value is held.
- Start from IDLE when Value is already terminal for the sampled Mode: no counting; the next edge gives DONE with Expired=1 and Tick=0.
- Pause and Start asserted together in RUN: Pause wins. Together in PAUSED: remain PAUSED.
- Load coincident with a tick edge: Load wins; no Tick, no Expired.
- Reset or Load mid-run aborts immediately; no Expired pulse.
- Mode changes after Start have no effect until the next Start from IDLE.
- Outputs are registered. Running and Done follow the state register.

Test Plan:
1. CLOCK_FREQUENCY=8, DIGITS=2, Speed=0: Load 0x12, Mode=1, Start -> Tick every 8 cycles, first Tick 8 cycles after Start; Value sequence 12, 11, 10, 09, ... 01, 00. Expired pulses once with Value=00, then Done=1 and Value holds 00.
2. Same setup, Load 0x95, Mode=0, Start -> Value 96..99; Expired pulses on 99, Done=1, no wrap to 00. Further Start is ignored.
3. Load 0x30, Mode=1, Start; Pause 3 cycles into a period for 20 cycles, then Start -> Value stays 30 during the pause. The next Tick comes 5 cycles after resume and gives Value=29 (borrow ripple).
4. Speed=2 with CLOCK_FREQUENCY=8 -> Tick period 2 cycles. Change Speed to 0 mid-period -> the current period completes at 2; subsequent periods are 8.
5. Load 0x00, Mode=1, Start -> next cycle Expired=1, Done=1, Tick=0. Load 0xAF -> Value=99 (clamped).
6. Mid-run Reset, and separately Load on the same cycle as a due Tick -> Value=00 (Reset) or LoadValue (Load); Tick=0, Expired=0; state IDLE.

Source files
------------

// File: rtl/game_timer_bcd.sv
// game_timer_bcd: multi-digit BCD game timer with load, up/down count, pause/resume,
// speed scaling and a terminal-count pulse.
module game_timer_bcd #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DIGITS = 2
) (
  input  logic                  ClockIn,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  input  logic                  Start,
  input  logic                  Pause,
  input  logic                  Mode,
  input  logic [1:0]            Speed,
  output logic [4*DIGITS-1:0]   Value,
  output logic                  Running,
  output logic                  Tick,
  output logic                  Expired,
  output logic                  Done
);
  localparam int DW = $clog2(CLOCK_FREQUENCY);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t r_state;
  logic [DW-1:0] r_div;
  logic r_down, r_tick, r_exp;
  logic [4*DIGITS-1:0] r_value;
  logic [DW-1:0] w_reload;
  logic [4*DIGITS-1:0] w_next, w_clamp, w_nines;
  logic w_carry, w_last, w_term_start;
  logic [3:0] w_d;
  assign w_reload = DW'((CLOCK_FREQUENCY >> Speed) - 1);
  // w_carry ripples the borrow/carry from the ones digit upward within one cycle
  always_comb begin
    w_next = r_value;
    w_clamp = LoadValue;
    w_nines = '0;
    w_carry = 1'b1;
    w_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_value[4*i+:4];
      w_next[4*i+:4] = !w_carry ? w_d : r_down ? (w_d == 4'd0 ? 4'd9 : w_d - 4'd1) : (w_d == 4'd9 ? 4'd0 : w_d + 4'd1);
      w_carry = w_carry & (r_down ? w_d == 4'd0 : w_d == 4'd9);
      w_clamp[4*i+:4] = LoadValue[4*i+:4] > 4'd9 ? 4'd9 : LoadValue[4*i+:4];
      w_nines[4*i+:4] = 4'd9;
    end
  end
  assign w_last = r_down ? (w_next == '0) : (w_next == w_nines);
  assign w_term_start = Mode ? (r_value == '0) : (r_value == w_nines);
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_state <= IDLE;
      r_value <= '0;
      r_tick <= 1'b0;
      r_exp <= 1'b0;
      r_div <= w_reload;
      r_down <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      r_exp <= 1'b0;
      if (Load) begin
        r_state <= IDLE;
        r_value <= w_clamp;
        r_div <= w_reload;
      end else begin
        case (r_state)
          IDLE: if (Start && !Pause) begin
            r_down <= Mode;
            r_div <= w_reload;
            r_state <= w_term_start ? DONE : RUN;
            r_exp <= w_term_start;
          end
          RUN: if (Pause) r_state <= PAUSED;
          else if (r_div == '0) begin
            r_value <= w_next;
            r_tick <= 1'b1;
            r_div <= w_reload;
            r_exp <= w_last;
            r_state <= w_last ? DONE : RUN;
          end else r_div <= r_div - 1'b1;
          PAUSED: if (Start && !Pause) r_state <= RUN;
          default: r_state <= DONE;
        endcase
      end
    end
  end
  assign Value = r_value;
  assign Tick = r_tick;
  assign Expired = r_exp;
  assign Running = (r_state == RUN);
  assign Done = (r_state == DONE);
endmodule

// File: tb/tb_game_timer_bcd.sv
// tb_game_timer_bcd: directed scoreboard bench for game_timer_bcd at CLOCK_FREQUENCY=8, DIGITS=2.
module tb_game_timer_bcd;
  localparam int CF = 8;
  localparam int D = 2;
  logic ClockIn = 1'b0, Reset = 1'b1, Load = 1'b0, Start = 1'b0, Pause = 1'b0, Mode = 1'b0;
  logic [4*D-1:0] LoadValue = '0;
  logic [1:0] Speed = '0;
  logic [4*D-1:0] Value;
  logic Running, Tick, Expired, Done;
  typedef struct {logic [7:0] v; logic t; logic e; int c;} ev_t;
  ev_t q[$];
  ev_t mx;
  int cyc = 0, n_cmp = 0, n_bad = 0, s = 0, r = 0;
  game_timer_bcd #(.CLOCK_FREQUENCY(CF), .DIGITS(D)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Load(Load), .LoadValue(LoadValue), .Start(Start),
    .Pause(Pause), .Mode(Mode), .Speed(Speed), .Value(Value), .Running(Running),
    .Tick(Tick), .Expired(Expired), .Done(Done)
  );
  always #5 ClockIn = ~ClockIn;
  always @(posedge ClockIn) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  always @(negedge ClockIn) if (Tick || Expired) begin
    if (q.size() == 0) chk("unexpected tick/expired", {30'd0, Tick, Expired}, 32'd0);
    else begin
      mx = q.pop_front();
      chk("tick value", 32'(Value), 32'(mx.v));
      chk("tick cycle", cyc, mx.c);
      chk("tick flag", 32'(Tick), 32'(mx.t));
      chk("expired flag", 32'(Expired), 32'(mx.e));
    end
  end
  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask
  task automatic push(input logic [7:0] v, input logic t, input logic e, input int c);
    q.push_back('{v, t, e, c});
  endtask
  task automatic load(input logic [7:0] v);
    Load = 1'b1;
    LoadValue = v;
    step();
    Load = 1'b0;
  endtask
  task automatic start(output int sc);
    Start = 1'b1;
    sc = cyc + 1;
    step();
    Start = 1'b0;
  endtask
  task automatic drain(input string tag, input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk(tag, q.size(), 0);
      q.delete();
    end
  endtask
  initial begin
    repeat (2) step();
    chk("reset value", 32'(Value), 0);
    chk("reset tick", 32'(Tick), 0);
    chk("reset expired", 32'(Expired), 0);
    chk("reset running", 32'(Running), 0);
    chk("reset done", 32'(Done), 0);
    Reset = 1'b0;
    step();
    // down count 12 -> 00, Mode toggled after Start must not matter
    Mode = 1'b1;
    load(8'h12);
    chk("t1 load value", 32'(Value), 32'h12);
    start(s);
    Mode = 1'b0;
    chk("t1 running", 32'(Running), 1);
    for (int k = 1; k <= 12; k++) push(bcd(12 - k), 1'b1, k == 12, s + 8 * k);
    drain("t1 drain timeout", 120);
    chk("t1 done", 32'(Done), 1);
    chk("t1 running after done", 32'(Running), 0);
    repeat (10) step();
    chk("t1 hold value", 32'(Value), 0);
    // up count 95 -> 99, no wrap, Start ignored in DONE
    Mode = 1'b0;
    load(8'h95);
    chk("t2 done cleared", 32'(Done), 0);
    start(s);
    for (int k = 1; k <= 4; k++) push(bcd(95 + k), 1'b1, k == 4, s + 8 * k);
    drain("t2 drain timeout", 50);
    chk("t2 done", 32'(Done), 1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (20) step();
    chk("t2 hold value", 32'(Value), 32'h99);
    chk("t2 still done", 32'(Done), 1);
    // pause after three counted cycles, Start+Pause together stays paused
    Mode = 1'b1;
    load(8'h30);
    start(s);
    repeat (3) step();
    Pause = 1'b1;
    repeat (15) step();
    Start = 1'b1;
    repeat (5) step();
    chk("t3 paused value", 32'(Value), 32'h30);
    chk("t3 paused running", 32'(Running), 0);
    Pause = 1'b0;
    r = cyc + 1;
    step();
    Start = 1'b0;
    push(8'h29, 1'b1, 1'b0, r + 5);
    drain("t3 drain timeout", 20);
    load(8'h00);
    // speed 2 then 0 mid-period
    Speed = 2'd2;
    Mode = 1'b1;
    load(8'h50);
    start(s);
    push(8'h49, 1'b1, 1'b0, s + 2);
    push(8'h48, 1'b1, 1'b0, s + 4);
    push(8'h47, 1'b1, 1'b0, s + 6);
    push(8'h46, 1'b1, 1'b0, s + 14);
    push(8'h45, 1'b1, 1'b0, s + 22);
    repeat (4) step();
    Speed = 2'd0;
    drain("t4 drain timeout", 40);
    load(8'h00);
    // start on an already-terminal value, then clamped load
    Mode = 1'b1;
    load(8'h00);
    start(s);
    push(8'h00, 1'b0, 1'b1, s);
    step();
    chk("t5 done", 32'(Done), 1);
    chk("t5 running", 32'(Running), 0);
    drain("t5 drain timeout", 5);
    load(8'hAF);
    chk("t5 clamped value", 32'(Value), 32'h99);
    chk("t5 done cleared", 32'(Done), 0);
    // mid-run reset
    Mode = 1'b1;
    load(8'h40);
    start(s);
    push(8'h39, 1'b1, 1'b0, s + 8);
    drain("t6 drain timeout", 20);
    repeat (3) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t6 reset value", 32'(Value), 0);
    chk("t6 reset running", 32'(Running), 0);
    chk("t6 reset done", 32'(Done), 0);
    chk("t6 reset tick", 32'(Tick), 0);
    chk("t6 reset expired", 32'(Expired), 0);
    // Load on the edge where a tick is due
    load(8'h21);
    start(s);
    push(8'h20, 1'b1, 1'b0, s + 8);
    drain("t6b drain timeout", 20);
    while (cyc < s + 15) step();
    Load = 1'b1;
    LoadValue = 8'h55;
    step();
    Load = 1'b0;
    chk("t6b load value", 32'(Value), 32'h55);
    chk("t6b tick", 32'(Tick), 0);
    chk("t6b expired", 32'(Expired), 0);
    chk("t6b running", 32'(Running), 0);
    repeat (10) step();
    chk("t6b idle hold", 32'(Value), 32'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
